// File: rtl/boot_mem_arbiter.sv
// -----------------------------------------------------------------------------
// boot_mem_arbiter
//
// Shares the 16-word boot memory port between the CPU and the SPI boot loader.
// Each legal access is sequenced into a SETUP cycle (write strobe) followed by
// a HOLD cycle (read capture), then a one-cycle DONE acknowledge. Illegal
// accesses are rejected straight from IDLE without a memory cycle and are
// counted in a saturating debug counter.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   boot_mode                1: loader has strict priority, 0: round-robin
//   cpu_req/we/addr/wdata    CPU request side
//   cpu_ack/err/rdata        CPU completion side (rdata held between acks)
//   ldr_*                    same set for the SPI boot loader
//   mem_cs/we/addr/din       memory pins (all registered)
//   mem_dout                 memory read data
//   err_cnt                  saturating count of rejected accesses
// -----------------------------------------------------------------------------
module boot_mem_arbiter #(
    parameter int unsigned ROM_TOP = 6,
    parameter int unsigned RAM_TOP = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        boot_mode,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic [15:0] cpu_rdata,
    input  logic        ldr_req,
    input  logic        ldr_we,
    input  logic [3:0]  ldr_addr,
    input  logic [15:0] ldr_wdata,
    output logic        ldr_ack,
    output logic        ldr_err,
    output logic [15:0] ldr_rdata,
    output logic        mem_cs,
    output logic        mem_we,
    output logic [3:0]  mem_addr,
    output logic [15:0] mem_din,
    input  logic [15:0] mem_dout,
    output logic [7:0]  err_cnt
);

    localparam logic [3:0] ROM_TOP_W = 4'(ROM_TOP);
    localparam logic [3:0] RAM_TOP_W = 4'(RAM_TOP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // An access is illegal if it is beyond the implemented range or writes ROM.
    function automatic logic is_illegal(input logic we, input logic [3:0] addr);
        is_illegal = (addr > RAM_TOP_W) || (we && (addr <= ROM_TOP_W));
    endfunction

    state_t      state_q, state_d;
    logic        last_ldr_q, last_ldr_d;     // 1: loader won the last grant
    logic        win_ldr_q, win_ldr_d;       // owner of the access in flight
    logic        rd_q, rd_d;                 // access in flight is a read
    logic        err_flag_q, err_flag_d;     // access in flight was rejected
    logic        cpu_ack_q, cpu_ack_d;
    logic        cpu_err_q, cpu_err_d;
    logic        ldr_ack_q, ldr_ack_d;
    logic        ldr_err_q, ldr_err_d;
    logic [15:0] cpu_rdata_q, cpu_rdata_d;
    logic [15:0] ldr_rdata_q, ldr_rdata_d;
    logic        mem_cs_q, mem_cs_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_addr_q, mem_addr_d;
    logic [15:0] mem_din_q, mem_din_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic        pick_ldr;
    logic        sel_we;
    logic [3:0]  sel_addr;
    logic [15:0] sel_wdata;

    // Arbitration: strict loader priority in boot mode, otherwise the
    // requester that did not win last takes a tie.
    always_comb begin
        pick_ldr = 1'b0;
        if (boot_mode) begin
            pick_ldr = ldr_req;
        end else if (cpu_req && ldr_req) begin
            pick_ldr = ~last_ldr_q;
        end else begin
            pick_ldr = ldr_req;
        end
        sel_we    = pick_ldr ? ldr_we    : cpu_we;
        sel_addr  = pick_ldr ? ldr_addr  : cpu_addr;
        sel_wdata = pick_ldr ? ldr_wdata : cpu_wdata;
    end

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        state_d     = state_q;
        last_ldr_d  = last_ldr_q;
        win_ldr_d   = win_ldr_q;
        rd_d        = rd_q;
        err_flag_d  = err_flag_q;
        cpu_ack_d   = 1'b0;
        cpu_err_d   = 1'b0;
        ldr_ack_d   = 1'b0;
        ldr_err_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        ldr_rdata_d = ldr_rdata_q;
        mem_cs_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        err_cnt_d   = err_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req || ldr_req) begin
                    win_ldr_d  = pick_ldr;
                    last_ldr_d = pick_ldr;
                    rd_d       = ~sel_we;
                    if (is_illegal(sel_we, sel_addr)) begin
                        // Rejected: acknowledge straight away, memory untouched.
                        err_flag_d = 1'b1;
                        state_d    = ST_DONE;
                        if (pick_ldr) begin
                            ldr_ack_d = 1'b1;
                            ldr_err_d = 1'b1;
                            if (!sel_we) begin
                                ldr_rdata_d = 16'h0000;
                            end else begin
                                ldr_rdata_d = ldr_rdata_q;
                            end
                        end else begin
                            cpu_ack_d = 1'b1;
                            cpu_err_d = 1'b1;
                            if (!sel_we) begin
                                cpu_rdata_d = 16'h0000;
                            end else begin
                                cpu_rdata_d = cpu_rdata_q;
                            end
                        end
                    end else begin
                        err_flag_d = 1'b0;
                        state_d    = ST_SETUP;
                        mem_cs_d   = 1'b1;
                        mem_we_d   = sel_we;
                        mem_addr_d = sel_addr;
                        mem_din_d  = sel_wdata;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                // Write strobe drops for HOLD; address and data stay put.
                mem_cs_d = 1'b1;
                mem_we_d = 1'b0;
                state_d  = ST_HOLD;
            end
            ST_HOLD: begin
                state_d = ST_DONE;
                if (win_ldr_q) begin
                    ldr_ack_d = 1'b1;
                    if (rd_q) begin
                        ldr_rdata_d = mem_dout;
                    end else begin
                        ldr_rdata_d = ldr_rdata_q;
                    end
                end else begin
                    cpu_ack_d = 1'b1;
                    if (rd_q) begin
                        cpu_rdata_d = mem_dout;
                    end else begin
                        cpu_rdata_d = cpu_rdata_q;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (err_flag_q && (err_cnt_q != 8'hFF)) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end else begin
                    err_cnt_d = err_cnt_q;
                end
                err_flag_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_ldr_q  <= 1'b1;
            win_ldr_q   <= 1'b0;
            rd_q        <= 1'b0;
            err_flag_q  <= 1'b0;
            cpu_ack_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
            ldr_ack_q   <= 1'b0;
            ldr_err_q   <= 1'b0;
            cpu_rdata_q <= 16'h0000;
            ldr_rdata_q <= 16'h0000;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 4'h0;
            mem_din_q   <= 16'h0000;
            err_cnt_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            last_ldr_q  <= last_ldr_d;
            win_ldr_q   <= win_ldr_d;
            rd_q        <= rd_d;
            err_flag_q  <= err_flag_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_err_q   <= cpu_err_d;
            ldr_ack_q   <= ldr_ack_d;
            ldr_err_q   <= ldr_err_d;
            cpu_rdata_q <= cpu_rdata_d;
            ldr_rdata_q <= ldr_rdata_d;
            mem_cs_q    <= mem_cs_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign cpu_err   = cpu_err_q;
    assign cpu_rdata = cpu_rdata_q;
    assign ldr_ack   = ldr_ack_q;
    assign ldr_err   = ldr_err_q;
    assign ldr_rdata = ldr_rdata_q;
    assign mem_cs    = mem_cs_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_boot_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_boot_mem_arbiter: directed self-checking bench for boot_mem_arbiter.
// A small behavioural memory answers the memory pins; expected values are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_boot_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        boot_mode;
    logic        cpu_req, cpu_we;
    logic [3:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ack, cpu_err;
    logic [15:0] cpu_rdata;
    logic        ldr_req, ldr_we;
    logic [3:0]  ldr_addr;
    logic [15:0] ldr_wdata;
    logic        ldr_ack, ldr_err;
    logic [15:0] ldr_rdata;
    logic        mem_cs, mem_we;
    logic [3:0]  mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;
    logic [7:0]  err_cnt;

    logic [15:0] mem [16];

    int n_checks;
    int n_errors;

    boot_mem_arbiter #(.ROM_TOP(6), .RAM_TOP(11)) dut (
        .clk       (clk),
        .rst       (rst),
        .boot_mode (boot_mode),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_err   (cpu_err),
        .cpu_rdata (cpu_rdata),
        .ldr_req   (ldr_req),
        .ldr_we    (ldr_we),
        .ldr_addr  (ldr_addr),
        .ldr_wdata (ldr_wdata),
        .ldr_ack   (ldr_ack),
        .ldr_err   (ldr_err),
        .ldr_rdata (ldr_rdata),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: write commits on the edge that ends SETUP.
    always @(posedge clk) begin
        if (mem_cs && mem_we) mem[mem_addr] <= mem_din;
    end
    assign mem_dout = mem[mem_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One access from a single requester, started in an IDLE cycle.
    task automatic do_access(input string tag, input bit is_ldr, input logic we,
                             input logic [3:0] addr, input logic [15:0] wdata,
                             input int exp_lat, input bit exp_err,
                             input logic [15:0] exp_rdata, input int exp_cs, input int exp_we);
        int lat;
        int cs_n;
        int we_n;
        bit got;
        bit got_err;
        lat = 0; cs_n = 0; we_n = 0; got = 1'b0; got_err = 1'b0;
        if (is_ldr) begin
            ldr_req = 1'b1; ldr_we = we; ldr_addr = addr; ldr_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        while (!got && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (mem_cs) cs_n++;
            if (mem_cs && mem_we) we_n++;
            got     = is_ldr ? ldr_ack : cpu_ack;
            got_err = is_ldr ? ldr_err : cpu_err;
        end
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_err"}, got_err, exp_err);
        check({tag, "_rdata"}, is_ldr ? ldr_rdata : cpu_rdata, exp_rdata);
        check({tag, "_cs_cycles"}, cs_n, exp_cs);
        check({tag, "_we_cycles"}, we_n, exp_we);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cpu_ack"}, cpu_ack, 0);
        check({tag, "_cpu_err"}, cpu_err, 0);
        check({tag, "_ldr_ack"}, ldr_ack, 0);
        check({tag, "_ldr_err"}, ldr_err, 0);
        check({tag, "_mem_cs"}, mem_cs, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_din"}, mem_din, 0);
        check({tag, "_cpu_rdata"}, cpu_rdata, 0);
        check({tag, "_ldr_rdata"}, ldr_rdata, 0);
        check({tag, "_err_cnt"}, err_cnt, 0);
    endtask

    initial begin
        int who_a [4];
        int t_a [4];
        int n;
        int cpu_n;
        int ldr_n;
        int lat;

        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 16; i++) mem[i] = 16'hA000 + 16'(i);
        mem[4] = 16'hB007;
        boot_mode = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 4'h0; cpu_wdata = 16'h0000;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = 4'h0; ldr_wdata = 16'h0000;
        rst = 1'b0;
        #1;
        do_reset();
        check_all_zero("reset");

        // CPU read of ROM word 4.
        do_access("cpu_rd4", 1'b0, 1'b0, 4'd4, 16'h0000, 3, 1'b0, 16'hB007, 2, 0);

        // Loader write then read back of scratch word 9.
        do_access("ldr_wr9", 1'b1, 1'b1, 4'd9, 16'h1234, 3, 1'b0, 16'h0000, 2, 1);
        do_access("ldr_rd9", 1'b1, 1'b0, 4'd9, 16'h0000, 3, 1'b0, 16'h1234, 2, 0);

        // Rejected ROM write (rdata unchanged) and out-of-range read (rdata 0).
        do_access("cpu_wr3", 1'b0, 1'b1, 4'd3, 16'h5555, 1, 1'b1, 16'hB007, 0, 0);
        do_access("cpu_rd13", 1'b0, 1'b0, 4'd13, 16'h0000, 1, 1'b1, 16'h0000, 0, 0);
        check("err_cnt_2", err_cnt, 2);

        // Round-robin after reset: CPU wins the first tie, then alternation.
        do_reset();
        check_all_zero("reset2");
        for (int i = 0; i < 4; i++) begin who_a[i] = -1; t_a[i] = -1; end
        n = 0;
        boot_mode = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd4;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 4'd9;
        for (int c = 1; c <= 30 && n < 4; c++) begin
            @(posedge clk); #1;
            if (cpu_ack && n < 4) begin who_a[n] = 0; t_a[n] = c; n++; end
            if (ldr_ack && n < 4) begin who_a[n] = 1; t_a[n] = c; n++; end
        end
        cpu_req = 1'b0; ldr_req = 1'b0;
        check("rr_count", n, 4);
        check("rr_who0", who_a[0], 0);
        check("rr_who1", who_a[1], 1);
        check("rr_who2", who_a[2], 0);
        check("rr_who3", who_a[3], 1);
        check("rr_t0", t_a[0], 3);
        check("rr_gap1", t_a[1] - t_a[0], 4);
        check("rr_gap2", t_a[2] - t_a[1], 4);
        check("rr_gap3", t_a[3] - t_a[2], 4);
        check("rr_cpu_rdata", cpu_rdata, 16'hB007);
        check("rr_ldr_rdata", ldr_rdata, 16'h1234);
        @(posedge clk); #1;

        // Boot mode: loader served every time until it drops its request.
        boot_mode = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd4;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 4'd9;
        cpu_n = 0; ldr_n = 0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            if (cpu_ack) cpu_n++;
            if (ldr_ack) ldr_n++;
        end
        check("boot_ldr_acks", ldr_n, 4);
        check("boot_cpu_acks", cpu_n, 0);
        ldr_req = 1'b0;
        lat = 0;
        while (!cpu_ack && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        cpu_req = 1'b0;
        check("boot_cpu_lat", lat, 3);
        check("boot_cpu_rdata", cpu_rdata, 16'hB007);
        boot_mode = 1'b0;
        @(posedge clk); #1;

        // Reset during HOLD of a CPU read aborts it without an ack.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd5;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("hold_mem_cs", mem_cs, 1);
        rst = 1'b1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check_all_zero("midrst");
        cpu_n = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (cpu_ack) cpu_n++;
        end
        check("midrst_no_ack", cpu_n, 0);
        do_access("post_rst_rd4", 1'b0, 1'b0, 4'd4, 16'h0000, 3, 1'b0, 16'hB007, 2, 0);

        // 300 back-to-back rejected reads saturate the error counter.
        n = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd12;
        for (int c = 0; c < 1000 && n < 300; c++) begin
            @(posedge clk); #1;
            if (cpu_ack) begin
                n++;
                if (n == 100) check("err_cnt_99", err_cnt, 99);
            end
        end
        cpu_req = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("sat_acks", n, 300);
        check("err_cnt_sat", err_cnt, 8'hFF);
        check("sat_rdata", cpu_rdata, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/boot_mem_arbiter.md
# boot_mem_arbiter

Shares the 16-word boot memory port (read-only words, patch word and scratch RAM) between the CPU fetch/data path and the SPI boot loader. It sequences every access into a fixed setup/hold cycle pair on the memory's `cs`/`we`/`addr`/`din` pins, captures read data, and rejects illegal accesses without touching memory. Arbitration is strict loader priority during boot and round-robin afterwards. A saturating error counter is exposed for debug.

## Interface
Parameters:
- `ROM_TOP`, 6: highest read-only address; writes to 0..`ROM_TOP` are rejected.
- `RAM_TOP`, 11: highest implemented address; any access above it is rejected.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `boot_mode`  in  1  1 = loader has strict priority; 0 = round-robin.
- `cpu_req`  in  1  CPU request; held until `cpu_ack`.
- `cpu_we`  in  1  CPU write (1) / read (0).
- `cpu_addr`  in  4  CPU word address.
- `cpu_wdata`  in  16  CPU write data.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_err`  out  1  valid with `cpu_ack`; access rejected.
- `cpu_rdata`  out  16  read data; valid with `cpu_ack`, held until the next CPU ack.
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata`, `ldr_ack`, `ldr_err`, `ldr_rdata`: same as the CPU ports, for the loader.
- `mem_cs`  out  1  memory chip select.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  4  memory address.
- `mem_din`  out  16  memory write data.
- `mem_dout`  in  16  memory read data; valid while `mem_cs`=1 and `mem_we`=0.
- `err_cnt`  out  8  count of rejected accesses, saturating.

## Operation
- States: IDLE, SETUP, HOLD, DONE.
- **IDLE**
  - When any `req` is high, pick a winner and latch its `we`, `addr` and `wdata`.
  - Illegal access (`addr` > `RAM_TOP`, or write with `addr` ≤ `ROM_TOP`): go to DONE with the error flag set. No memory cycle is issued.
  - Legal access: go to SETUP.
- **SETUP**
  - `mem_cs`=1, `mem_we`=latched `we`, `mem_addr` and `mem_din` driven from the latch.
  - The write commits at the rising edge that ends SETUP.
  - Always go to HOLD.
- **HOLD**
  - `mem_cs`=1, `mem_we`=0, address and data unchanged.
  - For a read, `mem_dout` is captured into the winner's `rdata` register at the end of HOLD.
  - Always go to DONE.
- **DONE**
  - Winner's `ack`=1 for exactly one cycle, with `err` as latched.
  - `mem_cs`=0 and `mem_we`=0.
  - Go to IDLE.
- **Arbitration**
  - `boot_mode`=1: loader wins whenever `ldr_req`=1.
  - `boot_mode`=0: round-robin. On a tie, the requester that did not win last wins.
  - `last_grant` resets to loader, so the CPU wins the first tie.
- Requester fields are sampled only in IDLE. Changes during an access are ignored.
- Dropping `req` before `ack` does not abort the access; the `ack` still pulses.
- A requester must drop `req` in the cycle after `ack`, or it is treated as a new request.
- Rejected reads return `rdata`=16'h0000. Rejected writes leave `rdata` unchanged.
- `err_cnt` increments by 1 in each DONE cycle with the error flag set, and saturates at 8'hFF.

## Timing
- **Reset values.** On a clock edge with `rst`=1, the following all become 0:
  - state→IDLE;
  - all `ack`, `err`, `mem_cs`, `mem_we`;
  - `mem_addr`, `mem_din`, both `rdata`, `err_cnt`.
- **Reset mid-access.** Reset aborts any access in progress, and no `ack` is issued for it. A write whose SETUP cycle had already ended before reset has committed.
- **Legal access latency.** `req` sampled in IDLE at cycle N → SETUP at N+1 → HOLD at N+2 → `ack` at N+3. Next IDLE is N+4.
- **Rejected access latency.** `ack` and `err` at N+1.
- **Back-to-back.** A second requester waiting during an access is granted in the IDLE cycle after DONE. Worst-case wait is one access (4 cycles) when `boot_mode`=0.
- `boot_mode` is sampled only in IDLE.

## Test plan
- Reset, then CPU read addr 4 (memory returns 16'hB007) → `cpu_ack` 3 cycles after the request; `cpu_rdata`=16'hB007, `cpu_err`=0; `mem_cs` high for exactly 2 cycles with `mem_we`=0.
- Loader write 16'h1234 to addr 9, then loader read addr 9 → write shows `mem_we`=1 only in SETUP; the read returns 16'h1234.
- CPU write to addr 3, then CPU read addr 13 → both `cpu_ack` 1 cycle after the request with `cpu_err`=1; `mem_cs` stays 0; the read gives `cpu_rdata`=0; `err_cnt`=2.
- `boot_mode`=0, both requesters held continuously → grants alternate CPU, loader, CPU, loader, with `ack`s 4 cycles apart.
- `boot_mode`=1, both requesters held → loader is served every time and the CPU is not acked until `ldr_req` drops.
- Assert `rst` during HOLD of a CPU read → no `cpu_ack`; all outputs 0 on the next cycle; a new request completes normally. Separately, force 300 rejected accesses → `err_cnt`=8'hFF.
